// File: rtl/booth_arb_pkg.sv
// Shared defaults and the in-flight tag for the Booth multiplier arbiter.
package booth_arb_pkg;

  localparam int DEF_N       = 13;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_MUL_LAT = 4;
  localparam int ID_W        = $clog2(DEF_NUM_REQ);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant over an eligible vector; zero latency, pointer advances
// past the winner on each falling-edge grant, no backpressure of its own.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clkn_i,
  input  logic                       rstn_i,
  input  logic [NUM_REQ-1:0]         eligible,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int GW = $clog2(NUM_REQ);

  // ptr is the index with highest priority in the next arbitration.
  logic [GW-1:0] ptr;
  logic          found;
  int            idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = GW'(idx);
      end
    end
  end

  always_ff @(negedge clkn_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one pipelined N x N multiplier among NUM_REQ requesters, one issue per cycle.
// Result appears MUL_LAT+1 edges after accept; a requester with an unconsumed result is not re-granted.
module booth_mul_arbiter
  import booth_arb_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic                   clkn_i,
  input  logic                   rstn_i,
  input  logic                   en_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [NUM_REQ*N-1:0]   req_a_i,
  input  logic [NUM_REQ*N-1:0]   req_b_i,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  input  logic [NUM_REQ-1:0]     rsp_ready_i,
  output logic [NUM_REQ*2*N-1:0] rsp_p_o,
  output logic [N-1:0]           mul_a_o,
  output logic [N-1:0]           mul_b_o,
  input  logic [2*N-1:0]         mul_p_i,
  output logic                   idle_o
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int PW = 2 * N;

  logic [NUM_REQ-1:0] busy;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] capture;
  logic [NUM_REQ-1:0] consume;
  logic [GW-1:0]      gnt_id;
  tag_t               tag_pipe [MUL_LAT+1];
  tag_t               tag_last;

  // busy spans issue through consumption, so it also guarantees a free response slot.
  assign eligible = {NUM_REQ{en_i & rstn_i}} & req_valid_i & ~busy;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clkn_i   (clkn_i),
    .rstn_i   (rstn_i),
    .eligible (eligible),
    .grant    (grant),
    .grant_id (gnt_id)
  );

  assign req_ready_o = grant;
  assign consume     = rsp_valid_o & rsp_ready_i;
  assign tag_last    = tag_pipe[MUL_LAT];
  assign idle_o      = ~|busy;

  always_comb begin
    capture = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      capture[i] = tag_last.valid && (tag_last.id == ID_W'(i));
    end
  end

  always_ff @(negedge clkn_i or negedge rstn_i) begin
    if (!rstn_i) begin
      busy        <= '0;
      rsp_valid_o <= '0;
      rsp_p_o     <= '0;
      mul_a_o     <= '0;
      mul_b_o     <= '0;
      for (int s = 0; s <= MUL_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      busy        <= (busy | grant) & ~consume;
      rsp_valid_o <= (rsp_valid_o | capture) & ~consume;
      tag_pipe[0].valid <= |grant;
      tag_pipe[0].id    <= ID_W'(gnt_id);
      for (int s = 1; s <= MUL_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
      if (|grant) begin
        mul_a_o <= req_a_i[int'(gnt_id)*N +: N];
        mul_b_o <= req_b_i[int'(gnt_id)*N +: N];
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (capture[i]) rsp_p_o[i*PW +: PW] <= mul_p_i;
      end
    end
  end

  // A capture can only target an empty buffer, so it never meets a consume.
  always_ff @(negedge clkn_i) begin
    if (rstn_i) assert (!(|(capture & consume)));
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with a behavioural 4-stage multiplier and per-requester scoreboard.
module tb_booth_mul_arbiter;

  localparam int N  = 13;
  localparam int NR = 4;
  localparam int ML = 4;
  localparam int PW = 2 * N;

  logic             clkn_i;
  logic             rstn_i;
  logic             en_i;
  logic [NR-1:0]    req_valid_i;
  logic [NR-1:0]    req_ready_o;
  logic [NR*N-1:0]  req_a_i;
  logic [NR*N-1:0]  req_b_i;
  logic [NR-1:0]    rsp_valid_o;
  logic [NR-1:0]    rsp_ready_i;
  logic [NR*PW-1:0] rsp_p_o;
  logic [N-1:0]     mul_a_o;
  logic [N-1:0]     mul_b_o;
  logic [PW-1:0]    mul_p_i;
  logic             idle_o;

  booth_mul_arbiter #(.N(N), .NUM_REQ(NR), .MUL_LAT(ML)) dut (
    .clkn_i      (clkn_i),
    .rstn_i      (rstn_i),
    .en_i        (en_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_p_o     (rsp_p_o),
    .mul_a_o     (mul_a_o),
    .mul_b_o     (mul_b_o),
    .mul_p_i     (mul_p_i),
    .idle_o      (idle_o)
  );

  initial clkn_i = 1'b1;
  always #5 clkn_i = ~clkn_i;

  // Multiplier: product of operands registered at edge k is on mul_p_i after edge k+ML.
  logic [PW-1:0] mp [ML];
  always @(negedge clkn_i) begin
    mp[0] <= PW'(mul_a_o) * PW'(mul_b_o);
    for (int s = 1; s < ML; s++) mp[s] <= mp[s-1];
  end
  assign mul_p_i = mp[ML-1];

  int            errs;
  int            checks;
  int            rsp_cnt;
  logic [NR-1:0] gnt_seen;
  logic [PW-1:0] exp_q [NR][$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle: score accepts and consumes; then move to just after the next falling edge.
  task automatic step();
    @(posedge clkn_i);
    gnt_seen = req_ready_o;
    if (rstn_i) begin
      for (int i = 0; i < NR; i++) begin
        if (req_valid_i[i] && req_ready_o[i])
          exp_q[i].push_back(PW'(req_a_i[i*N +: N]) * PW'(req_b_i[i*N +: N]));
        if (rsp_valid_o[i] && rsp_ready_i[i]) begin
          rsp_cnt++;
          check("rsp_pending", 64'(exp_q[i].size() != 0), 64'd1);
          if (exp_q[i].size() != 0) check("rsp_prod", rsp_p_o[i*PW +: PW], exp_q[i].pop_front());
        end
      end
    end
    @(negedge clkn_i);
    #1;
  endtask

  task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    req_a_i[i*N +: N] = a;
    req_b_i[i*N +: N] = b;
  endtask

  task automatic do_reset();
    rstn_i      = 1'b0;
    en_i        = 1'b1;
    req_valid_i = '0;
    rsp_ready_i = '0;
    #3;
    check("rst_ready", req_ready_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_mul_a", mul_a_o, 0);
    check("rst_mul_b", mul_b_o, 0);
    check("rst_idle", idle_o, 1);
    for (int i = 0; i < NR; i++) begin
      check("rst_rsp_p", rsp_p_o[i*PW +: PW], 0);
      exp_q[i].delete();
    end
    @(posedge clkn_i);
    rstn_i = 1'b1;
    @(negedge clkn_i);
    #1;
  endtask

  initial begin
    int exp_g, n0, n2, n1, chg, base, bad;
    logic          have1;
    logic [PW-1:0] p1;
    errs = 0; checks = 0; rsp_cnt = 0;
    rstn_i = 1'b1; en_i = 1'b1; req_valid_i = '0; rsp_ready_i = '0;
    req_a_i = '0; req_b_i = '0;
    #1;
    do_reset();

    // Single op at full-scale operands, latency edge by edge.
    set_op(0, 13'd8191, 13'd8191);
    req_valid_i = 4'b0001;
    #1;
    check("t1_ready", req_ready_o, 4'b0001);
    step();
    req_valid_i = '0;
    check("t1_mul_a", mul_a_o, 8191);
    check("t1_mul_b", mul_b_o, 8191);
    check("t1_busy", idle_o, 0);
    for (int j = 1; j <= ML; j++) begin
      step();
      check("t1_early", rsp_valid_o, 0);
    end
    step();
    check("t1_valid", rsp_valid_o, 4'b0001);
    check("t1_prod", rsp_p_o[PW-1:0], 26'h3FFC001);
    rsp_ready_i = 4'b0001;
    step();
    rsp_ready_i = '0;
    check("t1_consumed", rsp_valid_o, 0);
    check("t1_hold", rsp_p_o[PW-1:0], 26'h3FFC001);
    check("t1_idle", idle_o, 1);

    // All requesters at once: consecutive grants 0..3.
    do_reset();
    for (int i = 0; i < NR; i++) set_op(i, N'(i + 1), 13'd100);
    req_valid_i = '1;
    rsp_ready_i = '1;
    #1;
    for (int g = 0; g < NR; g++) begin
      check("t2_grant", req_ready_o, 64'(1 << g));
      step();
    end
    req_valid_i = '0;
    base = rsp_cnt;
    for (int j = 0; j < 10; j++) step();
    check("t2_rsp_cnt", rsp_cnt - base, 4);
    for (int i = 0; i < NR; i++) check("t2_prod", rsp_p_o[i*PW +: PW], 64'((i + 1) * 100));
    check("t2_idle", idle_o, 1);

    // Fairness between 0 and 2 with immediate consumption.
    exp_g = 0; n0 = 0; n2 = 0;
    req_valid_i = 4'b0101;
    for (int j = 0; j < 40; j++) begin
      set_op(0, N'($urandom), N'($urandom));
      set_op(2, N'($urandom), N'($urandom));
      step();
      if (gnt_seen != 0) begin
        check("t3_alternate", gnt_seen, 64'(1 << exp_g));
        if (gnt_seen[0]) n0++;
        if (gnt_seen[2]) n2++;
        exp_g = (exp_g == 0) ? 2 : 0;
      end
    end
    req_valid_i = '0;
    for (int j = 0; j < 10; j++) step();
    check("t3_n0", 64'(n0 >= 5), 1);
    check("t3_n2", 64'(n2 >= 5), 1);
    check("t3_idle", idle_o, 1);

    // Requester 1 backpressured; others keep going.
    do_reset();
    rsp_ready_i = 4'b1101;
    req_valid_i = '1;
    n0 = 0; n1 = 0; chg = 0; have1 = 1'b0; p1 = '0;
    for (int j = 0; j < 24; j++) begin
      for (int i = 0; i < NR; i++) set_op(i, N'($urandom), N'($urandom));
      step();
      if (gnt_seen[0]) n0++;
      if (gnt_seen[1]) n1++;
      if (rsp_valid_o[1]) begin
        if (!have1) begin
          have1 = 1'b1;
          p1    = rsp_p_o[PW +: PW];
        end else if (rsp_p_o[PW +: PW] !== p1) chg++;
      end
    end
    check("t4_n1", n1, 1);
    check("t4_n0", 64'(n0 >= 2), 1);
    check("t4_stable", chg, 0);
    check("t4_held", rsp_valid_o[1], 1);
    req_valid_i = '0;
    rsp_ready_i = '1;
    step();
    check("t4_released", rsp_valid_o[1], 0);
    check("t4_p_after", rsp_p_o[PW +: PW], p1);
    for (int j = 0; j < 10; j++) step();
    check("t4_idle", idle_o, 1);

    // en_i drop with three ops in flight.
    do_reset();
    for (int i = 0; i < NR; i++) set_op(i, N'($urandom), N'($urandom));
    req_valid_i = 4'b0111;
    #1;
    for (int j = 0; j < 3; j++) step();
    check("t5_busy", idle_o, 0);
    en_i = 1'b0;
    req_valid_i = '1;
    #1;
    check("t5_ready_off", req_ready_o, 0);
    rsp_ready_i = '1;
    base = rsp_cnt; bad = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      if (gnt_seen != 0) bad++;
    end
    check("t5_no_grant", bad, 0);
    check("t5_rsp_cnt", rsp_cnt - base, 3);
    check("t5_idle", idle_o, 1);
    for (int i = 0; i < NR; i++) check("t5_q_empty", exp_q[i].size(), 0);
    en_i = 1'b1;
    req_valid_i = '0;

    // Async reset with two ops in flight.
    do_reset();
    req_valid_i = 4'b0011;
    #1;
    step();
    step();
    req_valid_i = '0;
    check("t6_busy", idle_o, 0);
    check("t6_mul_a", mul_a_o, req_a_i[N +: N]);
    #2;
    do_reset();
    rsp_ready_i = '1;
    base = rsp_cnt; bad = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      if (rsp_valid_o != 0) bad++;
    end
    check("t6_no_rsp", bad, 0);
    check("t6_rsp_cnt", rsp_cnt - base, 0);
    check("t6_idle", idle_o, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
